// File: rtl/fp_unit_rr_arbiter.sv
// rtl/fp_unit_rr_arbiter.sv - round-robin issue of N_REQ requesters onto one fixed-latency pipelined FP core
// One op per cycle to the core, a tag pipe matched to core latency, and a per-requester result holding register.
module fp_unit_rr_arbiter #(
    parameter int          N_REQ         = 4,
    parameter int          WIDTH         = 32,
    parameter int          LATENCY       = 4,
    parameter logic [31:0] OPS_DONE_INIT = 32'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [N_REQ*WIDTH-1:0]   rsp_data,
    output logic [WIDTH-1:0]         unit_din0,
    output logic [WIDTH-1:0]         unit_din1,
    input  logic [WIDTH-1:0]         unit_dout,
    output logic                     busy,
    output logic [31:0]              ops_done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] inflight;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] cap_mask;
    logic [N_REQ-1:0] inflight_next;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_next;
    logic [IW-1:0]    grant_id;
    logic             grant_found;
    int               scan_idx;
    logic [31:0]      pop_cnt;
    logic [LATENCY-1:0] tag_v;
    logic [IW-1:0]      tag_id [LATENCY];

    // Scan from the farthest offset down so the closest eligible index to ptr wins.
    always_comb begin
        elig        = req_valid & ~inflight & ~rsp_valid;
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            scan_idx = (int'(ptr) + off) % N_REQ;
            if (elig[IW'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_id    = IW'(scan_idx);
            end
        end
        req_ready = grant_found ? (N_REQ'(1) << grant_id) : '0;
        ptr_next  = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    always_comb begin
        pop      = rsp_valid & rsp_ready;
        pop_cnt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pop_cnt = pop_cnt + 32'(pop[i]);
        end
        cap_mask      = tag_v[LATENCY-1] ? (N_REQ'(1) << tag_id[LATENCY-1]) : '0;
        inflight_next = (inflight & ~cap_mask) | req_ready;
    end

    assign busy = (|inflight) | (|rsp_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            inflight  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            unit_din0 <= '0;
            unit_din1 <= '0;
            tag_v     <= '0;
            ops_done  <= OPS_DONE_INIT;
            for (int s = 0; s < LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_v[0]  <= grant_found;
            tag_id[0] <= grant_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            if (grant_found) begin
                unit_din0 <= req_a[grant_id*WIDTH +: WIDTH];
                unit_din1 <= req_b[grant_id*WIDTH +: WIDTH];
                ptr       <= ptr_next;
            end
            if (tag_v[LATENCY-1]) begin
                rsp_data[tag_id[LATENCY-1]*WIDTH +: WIDTH] <= unit_dout;
            end
            inflight  <= inflight_next;
            rsp_valid <= (rsp_valid & ~pop) | cap_mask;
            ops_done  <= ops_done + pop_cnt;
        end
    end

endmodule
